// File: rtl/out_port_scheduler.sv
// -----------------------------------------------------------------------------
// out_port_scheduler
//
// Round-robin scheduler sharing one registered output port among NUM_REQ
// requesters. In IDLE the scheduler samples req, picks the first set bit
// starting at the rotating pointer, registers that requester's data onto the
// port and holds it valid for HOLD_CYCLES cycles (HOLD state). It then drops
// port_valid for at least one IDLE cycle before it arbitrates again.
//
// Every output is driven directly by a flop so that port_data/port_valid can
// be constrained with output delays relative to src_clk.
//
// Parameters:
//   NUM_REQ      number of requesters (>= 2)
//   DATA_W       width of each requester's data word
//   HOLD_CYCLES  cycles port_valid stays high per grant (>= 1)
//
// Ports:
//   src_clk     in   1                rising-edge clock
//   rst         in   1                asynchronous active-high reset
//   req         in   NUM_REQ          request levels, bit i = requester i
//   req_data    in   NUM_REQ*DATA_W   requester i data at [i*DATA_W +: DATA_W]
//   gnt         out  NUM_REQ          one-hot grant, one-cycle pulse
//   port_data   out  DATA_W           registered port data
//   port_valid  out  1                high while port_data is valid
//   busy        out  1                high while in HOLD
// -----------------------------------------------------------------------------
module out_port_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                      src_clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         port_data,
    output logic                      port_valid,
    output logic                      busy
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;

    // -------------------------------------------------------------------------
    // Round-robin winner search
    // -------------------------------------------------------------------------
    logic                any_req;
    logic                found;
    logic [PW-1:0]       win;
    logic [PW-1:0]       idx;
    logic [DATA_W-1:0]   win_data;
    int unsigned         pos;

    assign any_req = |req;

    // Scan ptr, ptr+1, ... wrapping modulo NUM_REQ; the first set bit wins.
    // Modulo arithmetic keeps the wrap correct for non-power-of-two NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        pos   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = (int'(ptr_q) + i) % NUM_REQ;
            idx = PW'(pos);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Data mux for the winning requester.
    always_comb begin
        win_data = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (win == PW'(j)) begin
                win_data = req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = '0;           // grant is a single-cycle pulse
        data_d     = data_q;       // port_data holds its last value
        valid_d    = valid_q;
        busy_d     = busy_q;

        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (any_req) begin
                    gnt_d      = NUM_REQ'(1) << win;
                    data_d     = win_data;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                    hold_cnt_d = HOLD_LOAD;
                    ptr_d      = (win == LAST_IDX) ? '0 : win + PW'(1);
                    state_d    = HOLD;
                end
            end

            HOLD: begin
                // req is deliberately not looked at here.
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end else begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: straight from flops
    // -------------------------------------------------------------------------
    assign gnt        = gnt_q;
    assign port_data  = data_q;
    assign port_valid = valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_out_port_scheduler.sv
// -----------------------------------------------------------------------------
// tb_out_port_scheduler
//
// Directed bench for out_port_scheduler. One instance uses the default
// parameters (NUM_REQ=4, DATA_W=8, HOLD_CYCLES=2); a second instance with
// HOLD_CYCLES=1 shares clock and reset. Outputs are sampled 1 ns after each
// rising edge; inputs are changed at that same point, well away from the edge.
// -----------------------------------------------------------------------------
module tb_out_port_scheduler;

    logic        src_clk = 1'b0;
    logic        rst;

    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [7:0]  port_data;
    logic        port_valid;
    logic        busy;

    logic [3:0]  req1;
    logic [31:0] req_data1;
    logic [3:0]  gnt1;
    logic [7:0]  port_data1;
    logic        port_valid1;
    logic        busy1;

    int errors = 0;
    int checks = 0;

    always #5 src_clk = ~src_clk;

    out_port_scheduler #(
        .NUM_REQ     (4),
        .DATA_W      (8),
        .HOLD_CYCLES (2)
    ) dut (
        .src_clk    (src_clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .port_data  (port_data),
        .port_valid (port_valid),
        .busy       (busy)
    );

    out_port_scheduler #(
        .NUM_REQ     (4),
        .DATA_W      (8),
        .HOLD_CYCLES (1)
    ) dut1 (
        .src_clk    (src_clk),
        .rst        (rst),
        .req        (req1),
        .req_data   (req_data1),
        .gnt        (gnt1),
        .port_data  (port_data1),
        .port_valid (port_valid1),
        .busy       (busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge src_clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        req1      = '0;
        req_data1 = '0;

        // ---------------- reset values ----------------
        tick();
        tick();
        chk("rst_gnt",    gnt,        0);
        chk("rst_data",   port_data,  0);
        chk("rst_valid",  port_valid, 0);
        chk("rst_busy",   busy,       0);
        chk("rst1_valid", port_valid1, 0);
        rst = 1'b0;

        // ---------------- 1: single request ----------------
        req      = 4'b0010;
        req_data = {8'h00, 8'h00, 8'hA5, 8'h00};
        tick();
        chk("s1_e1_gnt",   gnt,        4'b0010);
        chk("s1_e1_data",  port_data,  8'hA5);
        chk("s1_e1_valid", port_valid, 1);
        chk("s1_e1_busy",  busy,       1);
        req = '0;
        tick();
        chk("s1_e2_gnt",   gnt,        0);
        chk("s1_e2_valid", port_valid, 1);
        chk("s1_e2_busy",  busy,       1);
        tick();
        chk("s1_e3_valid", port_valid, 0);
        chk("s1_e3_busy",  busy,       0);
        chk("s1_e3_data",  port_data,  8'hA5);

        // reset so the round-robin pointer starts at 0 again
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // ---------------- 2: continuous load ----------------
        req      = 4'b1111;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int r = 0; r < 5; r++) begin
            tick();
            chk("s2_gnt",        gnt,        32'(1) << (r % 4));
            chk("s2_data",       port_data,  8'h10 + (r % 4));
            chk("s2_valid",      port_valid, 1);
            tick();
            chk("s2_hold_gnt",   gnt,        0);
            chk("s2_hold_valid", port_valid, 1);
            tick();
            chk("s2_idle_valid", port_valid, 0);
            chk("s2_idle_data",  port_data,  8'h10 + (r % 4));
        end
        req = '0;   // ptr is now 1

        // ---------------- 3: pointer wrap ----------------
        req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req      = 4'b0100;
        tick();
        chk("s3_g2_gnt",  gnt,       4'b0100);
        chk("s3_g2_data", port_data, 8'hC2);
        req = 4'b1010;
        tick();
        tick();
        chk("s3_idle_valid", port_valid, 0);
        tick();
        chk("s3_g3_gnt",  gnt,       4'b1000);
        chk("s3_g3_data", port_data, 8'hD3);
        req = 4'b0010;
        tick();
        tick();
        tick();
        chk("s3_g1_gnt",  gnt,       4'b0010);
        chk("s3_g1_data", port_data, 8'hB1);

        // ---------------- 4: request dropped during HOLD ----------------
        req = 4'b0100;
        tick();
        chk("s4_hold_gnt",   gnt,        0);
        chk("s4_hold_valid", port_valid, 1);
        req = '0;
        tick();
        chk("s4_end_valid", port_valid, 0);
        tick();
        chk("s4_idle_gnt",   gnt,        0);
        chk("s4_idle_valid", port_valid, 0);
        tick();
        chk("s4_idle2_valid", port_valid, 0);
        chk("s4_idle2_busy",  busy,       0);
        chk("s4_idle2_data",  port_data,  8'hB1);

        // ---------------- 5: async reset mid-HOLD ----------------
        req_data = {8'hD3, 8'h5A, 8'hB1, 8'hA0};
        req      = 4'b0100;   // ptr is 2
        tick();
        chk("s5_g_gnt",   gnt,        4'b0100);
        chk("s5_g_data",  port_data,  8'h5A);
        chk("s5_g_valid", port_valid, 1);
        req = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("s5_ar_valid", port_valid, 0);
        chk("s5_ar_data",  port_data,  0);
        chk("s5_ar_gnt",   gnt,        0);
        chk("s5_ar_busy",  busy,       0);
        tick();
        chk("s5_held_valid", port_valid, 0);
        rst      = 1'b0;
        req      = 4'b1000;
        req_data = {8'hE7, 8'h5A, 8'hB1, 8'hA0};
        tick();
        chk("s5_r3_gnt",  gnt,       4'b1000);
        chk("s5_r3_data", port_data, 8'hE7);
        req = '0;
        tick();
        tick();
        chk("s5_end_valid", port_valid, 0);

        // ---------------- 6: HOLD_CYCLES = 1 ----------------
        req1      = 4'b0001;
        req_data1 = 32'h0000_0077;
        tick();
        chk("s6_r0_gnt",   gnt1,        4'b0001);
        chk("s6_r0_valid", port_valid1, 1);
        chk("s6_r0_data",  port_data1,  8'h77);
        req_data1 = 32'h0000_0078;
        tick();
        chk("s6_r0_low_valid", port_valid1, 0);
        chk("s6_r0_low_gnt",   gnt1,        0);
        chk("s6_r0_low_data",  port_data1,  8'h77);
        for (int r = 1; r < 3; r++) begin
            tick();
            chk("s6_gnt",      gnt1,        4'b0001);
            chk("s6_valid",    port_valid1, 1);
            chk("s6_data",     port_data1,  8'h78);
            tick();
            chk("s6_low_valid", port_valid1, 0);
            chk("s6_low_busy",  busy1,       0);
        end
        req1 = '0;
        tick();
        tick();
        chk("s6_quiet_valid", port_valid1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
